// File: rtl/layout_cell_assembler.sv
// rtl/layout_cell_assembler.sv - raster cell stream to oriented, double-buffered flat layout
//
// Collects W*H cells of S bits, one per in_valid/in_ready handshake, in raster
// order. Each cell is written to the working buffer at the index selected by
// the orientation latched at start. The finished layout is copied to dst on
// the edge that accepts the final cell, so dst only ever changes to a complete
// layout.
//
// Optional macro: LAYOUT_ASM_ABORT_EN adds the abort input.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, mode       begin a new layout (IDLE/DONE only), orientation 0..7
//   in_valid/in_ready cell handshake, in_cell carries S bits
//   abort             (LAYOUT_ASM_ABORT_EN only) drop the layout being filled
//   dst, dst_valid    last completed layout and its valid flag
//   busy, done        high while filling, one-cycle completion pulse
`timescale 1ns/1ps
module layout_cell_assembler #(
    parameter int W = 6,
    parameter int H = 6,
    parameter int S = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [S-1:0]     in_cell,
`ifdef LAYOUT_ASM_ABORT_EN
    input  logic             abort,
`endif
    output logic [W*H*S-1:0] dst,
    output logic             dst_valid,
    output logic             busy,
    output logic             done
);
    localparam int N  = W * H;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t         state;
    logic [RW-1:0]  row;
    logic [CW-1:0]  col;
    logic [2:0]     mode_q;
    logic [N*S-1:0] work_buf;
    logic [N*S-1:0] merged;
    int             ri;
    int             cj;
    int             k;
    logic           last_cell;

    // Destination cell index for the current source coordinate.
    always_comb begin
        ri = int'(row);
        cj = int'(col);
        case (mode_q)
            3'd1:    k = (H - 1 - ri) * W + cj;
            3'd2:    k = ri * W + (W - 1 - cj);
            3'd3:    k = (W - 1 - cj) * H + ri;
            3'd4:    k = cj * H + (H - 1 - ri);
            default: k = ri * W + cj;
        endcase
    end

    // Working buffer with the incoming cell placed; a compare per cell slot
    // avoids a variable-offset part select.
    always_comb begin
        merged = work_buf;
        for (int n = 0; n < N; n++) begin
            if (n == k) begin
                merged[n*S +: S] = in_cell;
            end
        end
    end

    assign last_cell = (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            mode_q    <= '0;
            work_buf  <= '0;
            dst       <= '0;
            dst_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode_q   <= mode;
                        row      <= '0;
                        col      <= '0;
                        work_buf <= '0;
                        state    <= FILL;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                    end
                end
                FILL: begin
`ifdef LAYOUT_ASM_ABORT_EN
                    if (abort) begin
                        state    <= IDLE;
                        work_buf <= '0;
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                    end else
`endif
                    if (in_valid && in_ready) begin
                        work_buf <= merged;
                        if (last_cell) begin
                            dst       <= merged;
                            dst_valid <= 1'b1;
                            done      <= 1'b1;
                            state     <= DONE;
                            busy      <= 1'b0;
                            in_ready  <= 1'b0;
                            row       <= '0;
                            col       <= '0;
                        end else if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_layout_cell_assembler.sv
// tb/tb_layout_cell_assembler.sv - scoreboard bench for layout_cell_assembler (W=3, H=2, S=4)
`timescale 1ns/1ps
module tb_layout_cell_assembler;
    localparam int W = 3;
    localparam int H = 2;
    localparam int S = 4;
    localparam int N = W * H;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2:0]     mode;
    logic           in_valid;
    logic           in_ready;
    logic [S-1:0]   in_cell;
`ifdef LAYOUT_ASM_ABORT_EN
    logic           abort;
`endif
    logic [N*S-1:0] dst;
    logic           dst_valid;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    layout_cell_assembler #(.W(W), .H(H), .S(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cell   (in_cell),
`ifdef LAYOUT_ASM_ABORT_EN
        .abort     (abort),
`endif
        .dst       (dst),
        .dst_valid (dst_valid),
        .busy      (busy),
        .done      (done)
    );

    int             n_checks = 0;
    int             n_pass = 0;
    logic [N*S-1:0] exp_q[$];
    logic [N*S-1:0] cur_dst = '0;
    logic           cur_valid = 1'b0;
    logic           mon_en = 1'b0;
    int             done_seen = 0;
    int             done_expected = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: place source cell (i,j) into the output grid of the chosen
    // orientation, then flatten that grid row-major.
    function automatic logic [N*S-1:0] model(input int m, input logic [S-1:0] c [N]);
        logic [N*S-1:0] res;
        int orow, ocol, owidth;
        res = '0;
        for (int i = 0; i < H; i++) begin
            for (int j = 0; j < W; j++) begin
                case (m)
                    1: begin orow = H - 1 - i; ocol = j;         owidth = W; end
                    2: begin orow = i;         ocol = W - 1 - j; owidth = W; end
                    3: begin orow = W - 1 - j; ocol = i;         owidth = H; end
                    4: begin orow = j;         ocol = H - 1 - i; owidth = H; end
                    default: begin orow = i;   ocol = j;         owidth = W; end
                endcase
                res[(orow*owidth + ocol)*S +: S] = c[i*W + j];
            end
        end
        return res;
    endfunction

    // Monitor: pops the expected layout on every done pulse, otherwise
    // requires dst/dst_valid to hold their last completed values.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 64'd1, 64'd0);
                end else begin
                    cur_dst = exp_q.pop_front();
                    check("dst_on_done", 64'(dst), 64'(cur_dst));
                end
                cur_valid = 1'b1;
                check("dst_valid_on_done", 64'(dst_valid), 64'd1);
                check("busy_ready_on_done", 64'({busy, in_ready}), 64'd0);
            end else begin
                check("dst_hold", 64'(dst), 64'(cur_dst));
                check("dst_valid_hold", 64'(dst_valid), 64'(cur_valid));
            end
        end
    end

    task automatic begin_layout(input int m, input logic [N*S-1:0] e);
        logic [2:0] m3;
        m3 = 3'(m);
        start = 1'b1;
        mode = m3;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Sends the first 'upto' cells; max_gap idle cycles (random if rnd) precede each.
    task automatic feed(input logic [S-1:0] c [N], input int upto, input int max_gap, input bit rnd);
        int  gap;
        bit  got;
        for (int n = 0; n < upto; n++) begin
            gap = rnd ? int'($urandom_range(0, max_gap)) : max_gap;
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_cell = c[n];
            got = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (in_ready) begin got = 1'b1; break; end
            end
            if (!got) check("in_ready_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        if (upto == N) done_expected++;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 10; t++) begin
            if (done_seen >= done_expected) break;
            @(posedge clk); #1;
        end
        if (done_seen < done_expected) check("done_timeout", 64'(done_seen), 64'(done_expected));
    endtask

    logic [S-1:0]   seq [N];
    logic [S-1:0]   rc [N];
    logic [N*S-1:0] fixed_exp [5];
    int             d0;

    initial begin
        for (int n = 0; n < N; n++) seq[n] = 4'(n + 1);
        fixed_exp[0] = 24'h654321;
        fixed_exp[1] = 24'h321654;
        fixed_exp[2] = 24'h456123;
        fixed_exp[3] = 24'h415263;
        fixed_exp[4] = 24'h362514;

        rst = 1'b1; start = 1'b0; mode = '0; in_valid = 1'b0; in_cell = '0;
`ifdef LAYOUT_ASM_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_dst", 64'(dst), 64'd0);
        check("reset_dst_valid", 64'(dst_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Every orientation with cells 1..6, in_valid held high.
        for (int m = 0; m < 5; m++) begin
            begin_layout(m, fixed_exp[m]);
            check("busy_in_fill", 64'({busy, in_ready}), 64'd3);
            feed(seq, N, 0, 1'b0);
            wait_done();
        end

        // in_valid low every other cycle; exactly one done pulse.
        d0 = done_seen;
        begin_layout(0, 24'h654321);
        feed(seq, N, 1, 1'b0);
        wait_done();
        repeat (3) begin @(posedge clk); #1; end
        check("gap_done_once", 64'(done_seen - d0), 64'd1);

        // Reset after the third cell abandons the layout.
        d0 = done_seen;
        begin_layout(4, 24'h362514);
        feed(seq, 3, 0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        cur_dst = '0;
        cur_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_in_ready", 64'(in_ready), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_dst_valid", 64'(dst_valid), 64'd0);
        @(posedge clk); #1;
        check("rst_mid_no_done", 64'(done_seen - d0), 64'd0);
        begin_layout(2, 24'h456123);
        feed(seq, N, 0, 1'b0);
        wait_done();

`ifdef LAYOUT_ASM_ABORT_EN
        begin_layout(0, 24'h654321);
        feed(seq, N, 0, 1'b0);
        wait_done();
        d0 = done_seen;
        begin_layout(1, 24'h321654);
        feed(seq, 4, 0, 1'b0);
        abort = 1'b1;
        in_valid = 1'b1;
        in_cell = 4'h5;
        @(posedge clk); #1;
        abort = 1'b0;
        in_valid = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("abort_idle", 64'({busy, in_ready}), 64'd0);
        repeat (4) begin @(posedge clk); #1; end
        check("abort_no_done", 64'(done_seen - d0), 64'd0);
        check("abort_dst_kept", 64'(dst), 64'h654321);
`endif

        // Random modes, cells, gaps and back-to-back starts (start while done is high).
        for (int it = 0; it < 24; it++) begin
            int  m;
            bit  b2b;
            m = int'($urandom_range(0, 7));
            for (int n = 0; n < N; n++) rc[n] = 4'($urandom_range(0, 15));
            begin_layout(m, model(m, rc));
            feed(rc, N, 2, 1'b1);
            b2b = 1'($urandom_range(0, 1));
            if (!b2b) begin
                wait_done();
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end
        wait_done();
        repeat (3) begin @(posedge clk); #1; end
        check("done_count", 64'(done_seen), 64'(done_expected));
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
